// File: rtl/shift_pkg.sv
// Shared constants for the operand-2 resolution stage: shift types, FSM states
// and bit positions of the data-processing operand-2 field.
package shift_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RS_WAIT = 1'b1
    } state_t;

    localparam int unsigned OP2_ROT_MSB  = 11;
    localparam int unsigned OP2_ROT_LSB  = 8;
    localparam int unsigned OP2_IMM8_MSB = 7;
    localparam int unsigned OP2_SHN_MSB  = 11;
    localparam int unsigned OP2_SHN_LSB  = 7;
    localparam int unsigned OP2_TYPE_MSB = 6;
    localparam int unsigned OP2_TYPE_LSB = 5;
    localparam int unsigned OP2_REG_BIT  = 4;
    localparam int unsigned OP2_RS_MSB   = 11;

endpackage

// File: rtl/shift_operand_stage_if.sv
// Upstream operand, Rs read port and downstream shifter channels of the stage.
interface shift_operand_stage_if #(
    parameter int DW   = 32,
    parameter int RA_W = 4
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic            in_imm;
    logic [11:0]     in_op2;
    logic [DW-1:0]   in_rm;
    logic            in_cflag;
    logic [RA_W-1:0] rs_addr;
    logic            rs_en;
    logic [DW-1:0]   rs_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   sh_a;
    logic [7:0]      sh_b;
    logic [1:0]      sh_d;
    logic            sh_cin;
    logic            sh_cout;

    modport slave (
        input  flush, in_valid, in_imm, in_op2, in_rm, in_cflag, rs_data, out_ready,
        output in_ready, rs_addr, rs_en, out_valid, sh_a, sh_b, sh_d, sh_cin, sh_cout
    );

    modport master (
        output flush, in_valid, in_imm, in_op2, in_rm, in_cflag, rs_data, out_ready,
        input  in_ready, rs_addr, rs_en, out_valid, sh_a, sh_b, sh_d, sh_cin, sh_cout
    );
endinterface

// File: rtl/shift_carry_calc.sv
// Architectural shifter carry-out for immediate-amount and register-amount shifts.
module shift_carry_calc
    import shift_pkg::*;
(
    input  logic [31:0] a,
    input  logic [7:0]  n,
    input  logic [1:0]  sh_type,
    input  logic        reg_form,
    input  logic        cflag,
    output logic        cout
);

    logic [4:0] up_idx;
    logic [4:0] dn_idx;

    always_comb begin
        up_idx = 5'(6'd32 - {1'b0, n[4:0]});
        dn_idx = n[4:0] - 5'd1;
        cout   = cflag;
        if (!reg_form) begin
            // Immediate amount 0 encodes LSL #0, LSR/ASR #32 or RRX
            case (sh_type)
                SH_LSL:         cout = (n[4:0] == 5'd0) ? cflag : a[up_idx];
                SH_LSR, SH_ASR: cout = (n[4:0] == 5'd0) ? a[31] : a[dn_idx];
                default:        cout = (n[4:0] == 5'd0) ? a[0]  : a[dn_idx];
            endcase
        end else if (n != 8'd0) begin
            case (sh_type)
                SH_LSL: cout = (n < 8'd32) ? a[up_idx] : ((n == 8'd32) ? a[0]  : 1'b0);
                SH_LSR: cout = (n < 8'd32) ? a[dn_idx] : ((n == 8'd32) ? a[31] : 1'b0);
                SH_ASR: cout = (n < 8'd32) ? a[dn_idx] : a[31];
                default: cout = (n[4:0] == 5'd0) ? a[31] : a[dn_idx];
            endcase
        end
    end

endmodule

// File: rtl/shift_operand_stage.sv
// Operand-2 resolution stage: decodes op2 into barrel-shifter controls and carry-out,
// fetching Rs for register-specified shifts, behind a valid/ready output register.
module shift_operand_stage
    import shift_pkg::*;
#(
    parameter int DW   = 32,
    parameter int RA_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    shift_operand_stage_if.slave io
);

    state_t        state_q, state_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] sh_a_q, sh_a_d;
    logic [7:0]    sh_b_q, sh_b_d;
    logic [1:0]    sh_d_q, sh_d_d;
    logic          sh_cin_q, sh_cin_d;
    logic          sh_cout_q, sh_cout_d;
    logic [DW-1:0] rm_q, rm_d;
    logic [1:0]    type_q, type_d;
    logic          cflag_q, cflag_d;

    logic [DW-1:0] calc_a;
    logic [7:0]    calc_n;
    logic [1:0]    calc_type;
    logic          calc_reg;
    logic          calc_cflag;
    logic          calc_cout;

    logic [3:0]    rot;
    logic [4:0]    imm_n;
    logic [1:0]    op_type;
    logic          reg_shift;
    logic          in_ready;
    logic          accept;
    logic          rs_data_unused;

    assign rot       = io.in_op2[OP2_ROT_MSB:OP2_ROT_LSB];
    assign imm_n     = io.in_op2[OP2_SHN_MSB:OP2_SHN_LSB];
    assign op_type   = io.in_op2[OP2_TYPE_MSB:OP2_TYPE_LSB];
    assign reg_shift = !io.in_imm && io.in_op2[OP2_REG_BIT];
    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || io.out_ready);
    assign accept    = io.in_valid && in_ready && !io.flush;

    assign rs_data_unused = ^io.rs_data[DW-1:8];

    // One carry calculator serves all three paths; RS_WAIT takes the latched operands
    always_comb begin
        calc_a     = io.in_rm;
        calc_n     = {3'b000, imm_n};
        calc_type  = op_type;
        calc_reg   = 1'b0;
        calc_cflag = io.in_cflag;
        if (state_q == ST_RS_WAIT) begin
            calc_a     = rm_q;
            calc_n     = io.rs_data[7:0];
            calc_type  = type_q;
            calc_reg   = 1'b1;
            calc_cflag = cflag_q;
        end else if (io.in_imm) begin
            calc_a    = {{(DW-8){1'b0}}, io.in_op2[OP2_IMM8_MSB:0]};
            calc_n    = {3'b000, rot, 1'b0};
            calc_type = (rot == 4'd0) ? SH_LSL : SH_ROR;
        end
    end

    shift_carry_calc u_carry (
        .a        (calc_a),
        .n        (calc_n),
        .sh_type  (calc_type),
        .reg_form (calc_reg),
        .cflag    (calc_cflag),
        .cout     (calc_cout)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !io.out_ready;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        sh_d_d      = sh_d_q;
        sh_cin_d    = sh_cin_q;
        sh_cout_d   = sh_cout_q;
        rm_d        = rm_q;
        type_d      = type_q;
        cflag_d     = cflag_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (reg_shift) begin
                        rm_d    = io.in_rm;
                        type_d  = op_type;
                        cflag_d = io.in_cflag;
                        state_d = ST_RS_WAIT;
                    end else begin
                        out_valid_d = 1'b1;
                        sh_a_d      = calc_a;
                        sh_b_d      = calc_n;
                        sh_d_d      = calc_type;
                        sh_cin_d    = io.in_cflag;
                        sh_cout_d   = calc_cout;
                        if (!io.in_imm && imm_n == 5'd0 &&
                            (op_type == SH_LSR || op_type == SH_ASR)) begin
                            sh_b_d = 8'd32;
                        end
                    end
                end
            end
            ST_RS_WAIT: begin
                // Slot was reserved at accept, so the load cannot be back-pressured
                out_valid_d = 1'b1;
                sh_a_d      = rm_q;
                sh_b_d      = calc_n;
                sh_d_d      = (calc_n == 8'd0) ? SH_LSL : type_q;
                sh_cin_d    = cflag_q;
                sh_cout_d   = calc_cout;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (io.flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            sh_d_q      <= '0;
            sh_cin_q    <= 1'b0;
            sh_cout_q   <= 1'b0;
            rm_q        <= '0;
            type_q      <= '0;
            cflag_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            sh_d_q      <= sh_d_d;
            sh_cin_q    <= sh_cin_d;
            sh_cout_q   <= sh_cout_d;
            rm_q        <= rm_d;
            type_q      <= type_d;
            cflag_q     <= cflag_d;
        end
    end

    assign io.in_ready  = in_ready;
    assign io.rs_addr   = io.in_op2[OP2_RS_MSB -: RA_W];
    assign io.rs_en     = accept && reg_shift;
    assign io.out_valid = out_valid_q;
    assign io.sh_a      = sh_a_q;
    assign io.sh_b      = sh_b_q;
    assign io.sh_d      = sh_d_q;
    assign io.sh_cin    = sh_cin_q;
    assign io.sh_cout   = sh_cout_q;

endmodule

// File: tb/tb_shift_operand_stage.sv
// Bench for shift_operand_stage: directed and random operands checked against
// an arithmetic model of the operand-2 shifter rules.
module tb_shift_operand_stage;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    shift_operand_stage_if #(.DW(32), .RA_W(4)) io ();

    shift_operand_stage #(.DW(32), .RA_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  b;
        logic [1:0]  d;
        logic        cin;
        logic        cout;
    } exp_t;

    // Carry as the last bit shifted out, computed on widened values
    function automatic logic carry_of(logic [1:0] t, logic [31:0] a, int unsigned n);
        logic [63:0]        w;
        logic signed [63:0] s;
        logic [31:0]        r;
        int unsigned        k;
        case (t)
            2'd0: begin w = {32'b0, a} << n; return w[32]; end
            2'd1: begin w = {a, 32'b0} >> n; return w[31]; end
            2'd2: begin s = {a, 32'b0}; s = s >>> n; return s[31]; end
            default: begin
                k = n % 32;
                r = (k == 0) ? a : ((a >> k) | (a << (32 - k)));
                return r[31];
            end
        endcase
    endfunction

    function automatic exp_t model(logic imm, logic [11:0] op2, logic [31:0] rm,
                                   logic cf, logic [31:0] rsd);
        exp_t        e;
        int unsigned n;
        logic [1:0]  t;
        e.cin = cf;
        t = op2[6:5];
        if (imm) begin
            n = 2 * op2[11:8];
            e.a = {24'b0, op2[7:0]};
            if (n == 0) begin
                e.b = 8'd0; e.d = 2'd0; e.cout = cf;
            end else begin
                e.b = 8'(n); e.d = 2'd3; e.cout = carry_of(2'd3, e.a, n);
            end
        end else if (!op2[4]) begin
            n = op2[11:7];
            e.a = rm; e.d = t; e.b = 8'(n);
            if (n != 0) e.cout = carry_of(t, rm, n);
            else begin
                case (t)
                    2'd0: e.cout = cf;
                    2'd1, 2'd2: begin e.b = 8'd32; e.cout = carry_of(t, rm, 32); end
                    default: e.cout = rm[0];
                endcase
            end
        end else begin
            n = rsd[7:0];
            e.a = rm;
            if (n == 0) begin
                e.b = 8'd0; e.d = 2'd0; e.cout = cf;
            end else begin
                e.b = 8'(n); e.d = t; e.cout = carry_of(t, rm, n);
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk($sformatf("%s.valid", tag), 32'(io.out_valid), 32'd1);
        chk($sformatf("%s.sh_a", tag), io.sh_a, e.a);
        chk($sformatf("%s.sh_b", tag), 32'(io.sh_b), 32'(e.b));
        chk($sformatf("%s.sh_d", tag), 32'(io.sh_d), 32'(e.d));
        chk($sformatf("%s.cin", tag), 32'(io.sh_cin), 32'(e.cin));
        chk($sformatf("%s.cout", tag), 32'(io.sh_cout), 32'(e.cout));
    endtask

    task automatic drive(input logic imm, input logic [11:0] op2, input logic [31:0] rm,
                         input logic cf);
        io.in_valid = 1'b1;
        io.in_imm   = imm;
        io.in_op2   = op2;
        io.in_rm    = rm;
        io.in_cflag = cf;
    endtask

    // Starts and ends just after a rising edge
    task automatic do_op(input string tag, input logic imm, input logic [11:0] op2,
                         input logic [31:0] rm, input logic cf, input logic [31:0] rsd);
        exp_t e;
        logic rg;
        e  = model(imm, op2, rm, cf, rsd);
        rg = !imm && op2[4];
        io.out_ready = 1'b1;
        drive(imm, op2, rm, cf);
        @(negedge clk);
        chk($sformatf("%s.in_ready", tag), 32'(io.in_ready), 32'd1);
        chk($sformatf("%s.rs_en", tag), 32'(io.rs_en), 32'(rg));
        if (rg) chk($sformatf("%s.rs_addr", tag), 32'(io.rs_addr), 32'(op2[11:8]));
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.in_rm    = ~rm;
        io.in_cflag = ~cf;
        if (rg) begin
            io.rs_data = rsd;
            @(negedge clk);
            chk($sformatf("%s.wait_valid", tag), 32'(io.out_valid), 32'd0);
            chk($sformatf("%s.wait_rs_en", tag), 32'(io.rs_en), 32'd0);
            @(posedge clk);
            #1;
            io.rs_data = $urandom;
        end
        @(negedge clk);
        chk_out(tag, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t        e1;
        exp_t        e2;
        logic        imm;
        logic [11:0] op2;
        logic [31:0] rm;
        logic [31:0] rsd;
        logic        cf;

        io.flush     = 1'b0;
        io.in_valid  = 1'b0;
        io.in_imm    = 1'b0;
        io.in_op2    = '0;
        io.in_rm     = '0;
        io.in_cflag  = 1'b0;
        io.rs_data   = '0;
        io.out_ready = 1'b1;

        #3;
        chk("rst.valid", 32'(io.out_valid), 32'd0);
        chk("rst.rs_en", 32'(io.rs_en), 32'd0);
        chk("rst.sh_a", io.sh_a, 32'd0);
        chk("rst.sh_b", 32'(io.sh_b), 32'd0);
        chk("rst.sh_d", 32'(io.sh_d), 32'd0);
        chk("rst.cin", 32'(io.sh_cin), 32'd0);
        chk("rst.cout", 32'(io.sh_cout), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        do_op("imm_rot4", 1'b1, 12'h4FF, 32'h0, 1'b0, 32'h0);
        do_op("imm_rot0", 1'b1, 12'h0FF, 32'h0, 1'b0, 32'h0);
        do_op("imm_rot0_c1", 1'b1, 12'h080, 32'h0, 1'b1, 32'h0);
        do_op("lsr_0", 1'b0, 12'h020, 32'h8000_0000, 1'b0, 32'h0);
        do_op("ror_0", 1'b0, 12'h060, 32'h0000_0001, 1'b0, 32'h0);
        do_op("lsl_0", 1'b0, 12'h000, 32'hFFFF_FFFF, 1'b1, 32'h0);
        do_op("reg_ror_0", 1'b0, 12'h270, 32'h1234_5678, 1'b1, 32'h0);
        do_op("reg_ror_32", 1'b0, 12'h270, 32'h8000_0000, 1'b0, 32'h20);
        do_op("reg_lsl_33", 1'b0, 12'h310, 32'hFFFF_FFFF, 1'b1, 32'h21);
        do_op("reg_lsl_32", 1'b0, 12'h310, 32'hFFFF_FFFF, 1'b0, 32'h20);
        do_op("reg_asr_200", 1'b0, 12'h550, 32'h8000_0000, 1'b0, 32'hC8);
        do_op("reg_lsr_33", 1'b0, 12'h530, 32'hFFFF_FFFF, 1'b1, 32'h21);

        // Back-pressure: output held for 3 cycles while a new operand waits
        e1 = model(1'b1, 12'h4FF, 32'h0, 1'b1, 32'h0);
        e2 = model(1'b0, 12'h0A0, 32'hF000_000F, 1'b0, 32'h0);
        io.out_ready = 1'b0;
        drive(1'b1, 12'h4FF, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 12'h0A0, 32'hF000_000F, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_out($sformatf("hold%0d", i), e1);
            chk($sformatf("hold%0d.in_ready", i), 32'(io.in_ready), 32'd0);
        end
        io.out_ready = 1'b1;
        #1;
        chk("release.in_ready", 32'(io.in_ready), 32'd1);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        @(negedge clk);
        chk_out("release", e2);
        @(posedge clk);
        #1;

        // Flush while Rs is outstanding
        drive(1'b0, 12'h310, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.flush    = 1'b1;
        io.rs_data  = 32'h5;
        @(negedge clk);
        chk("flush.wait_ready", 32'(io.in_ready), 32'd0);
        @(posedge clk);
        #1;
        io.flush = 1'b0;
        @(negedge clk);
        chk("flush.valid", 32'(io.out_valid), 32'd0);
        chk("flush.in_ready", 32'(io.in_ready), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("flush.valid2", 32'(io.out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Flush beats a simultaneous accept
        drive(1'b1, 12'h4FF, 32'h0, 1'b1);
        io.flush = 1'b1;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.flush    = 1'b0;
        @(negedge clk);
        chk("flush_acc.valid", 32'(io.out_valid), 32'd0);
        chk("flush_acc.in_ready", 32'(io.in_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 60; i++) begin
            imm = 1'($urandom_range(0, 1));
            op2 = 12'($urandom);
            rm  = $urandom;
            if ($urandom_range(0, 3) == 0) rm = 32'h8000_0001;
            cf  = 1'($urandom_range(0, 1));
            rsd = $urandom;
            case ($urandom_range(0, 5))
                0: rsd[7:0] = 8'd0;
                1: rsd[7:0] = 8'd32;
                2: rsd[7:0] = 8'd33;
                3: rsd[7:0] = 8'($urandom_range(1, 31));
                4: rsd[7:0] = 8'h40 | 8'($urandom_range(0, 31));
                default: ;
            endcase
            do_op($sformatf("rnd%0d", i), imm, op2, rm, cf, rsd);
        end

        // Asynchronous reset while an output is held
        io.out_ready = 1'b0;
        drive(1'b1, 12'h4FF, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst.valid", 32'(io.out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst.valid", 32'(io.out_valid), 32'd0);
        chk("arst.sh_a", io.sh_a, 32'd0);
        chk("arst.sh_b", 32'(io.sh_b), 32'd0);
        chk("arst.sh_d", 32'(io.sh_d), 32'd0);
        chk("arst.cin", 32'(io.sh_cin), 32'd0);
        chk("arst.cout", 32'(io.sh_cout), 32'd0);
        chk("arst.rs_en", 32'(io.rs_en), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d.valid", i), 32'(io.out_valid), 32'd0);
            chk($sformatf("post_rst%0d.in_ready", i), 32'(io.in_ready), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
